// File: rtl/seq_pkg.sv
// Shared definitions for the state sequencer and variable_clock: control FSM encoding,
// default dwell constants and the slow-state set.
package seq_pkg;

  localparam logic [1:0] FSM_IDLE   = 2'd0;
  localparam logic [1:0] FSM_RUN    = 2'd1;
  localparam logic [1:0] FSM_PAUSED = 2'd2;

  localparam logic [4:0] LAST_STATE_DEF = 5'd16;
  localparam logic [7:0] DWELL_FAST_DEF = 8'd45;
  localparam logic [7:0] DWELL_SLOW_DEF = 8'd135;

  // variable_clock keys its slow divider off this same membership test.
  function automatic logic is_slow(input logic [4:0] s);
    logic slow;
    case (s)
      5'd3, 5'd4, 5'd6, 5'd7, 5'd9, 5'd10, 5'd12, 5'd15: slow = 1'b1;
      default:                                             slow = 1'b0;
    endcase
    return slow;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable 8-bit dwell down-counter. expired flags the last tick of a dwell, i.e. the
// cycle on which a decrement would take the count to zero.
module dwell_timer (
  input  logic       fourtyfiveHz_clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge fourtyfiveHz_clock) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign expired = (count == 8'd1);

endmodule

// File: rtl/state_sequencer.sv
// Steps state through 1..LAST_STATE with per-state dwell times, under start/pause/skip
// control, optionally looping. running/paused are direct decodes of the control FSM.
module state_sequencer
  import seq_pkg::*;
#(
  parameter logic [4:0] LAST_STATE = LAST_STATE_DEF,
  parameter logic [7:0] DWELL_FAST = DWELL_FAST_DEF,
  parameter logic [7:0] DWELL_SLOW = DWELL_SLOW_DEF
) (
  input  logic       fourtyfiveHz_clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       skip,
  input  logic       loop_en,
  output logic [4:0] state,
  output logic       slow_state,
  output logic       running,
  output logic       paused,
  output logic       done
);

  logic [1:0] fsm, fsm_n;
  logic [4:0] state_n;
  logic       done_n;
  logic       ld;
  logic [7:0] ld_val;
  logic       dec;
  logic       expired;

  function automatic logic [7:0] dwell_for(input logic [4:0] k);
    return is_slow(k) ? DWELL_SLOW : DWELL_FAST;
  endfunction

  dwell_timer u_dwell (
    .fourtyfiveHz_clock (fourtyfiveHz_clock),
    .reset              (reset),
    .load               (ld),
    .load_val           (ld_val),
    .en                 (dec),
    .expired            (expired)
  );

  always_comb begin
    fsm_n   = fsm;
    state_n = state;
    done_n  = 1'b0;
    ld      = 1'b0;
    ld_val  = 8'd0;
    dec     = 1'b0;
    case (fsm)
      FSM_IDLE: begin
        if (start) begin
          fsm_n   = FSM_RUN;
          state_n = 5'd1;
          ld      = 1'b1;
          ld_val  = dwell_for(5'd1);
        end
      end
      FSM_RUN: begin
        // pause outranks skip; skip and a natural expiry collapse into one advance.
        if (pause) begin
          fsm_n = FSM_PAUSED;
        end else if (skip || expired) begin
          ld = 1'b1;
          if (state == LAST_STATE) begin
            done_n = 1'b1;
            if (loop_en) begin
              state_n = 5'd1;
              ld_val  = dwell_for(5'd1);
            end else begin
              fsm_n   = FSM_IDLE;
              state_n = 5'd0;
              ld_val  = 8'd0;
            end
          end else begin
            state_n = state + 5'd1;
            ld_val  = dwell_for(state + 5'd1);
          end
        end else begin
          dec = 1'b1;
        end
      end
      FSM_PAUSED: begin
        if (pause) begin
          fsm_n = FSM_RUN;
        end
      end
      default: begin
        fsm_n   = FSM_IDLE;
        state_n = 5'd0;
        ld      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge fourtyfiveHz_clock) begin
    if (reset) begin
      fsm   <= FSM_IDLE;
      state <= 5'd0;
      done  <= 1'b0;
    end else begin
      fsm   <= fsm_n;
      state <= state_n;
      done  <= done_n;
    end
  end

  assign slow_state = is_slow(state);
  assign running    = (fsm != FSM_IDLE);
  assign paused     = (fsm == FSM_PAUSED);

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: a default-parameter instance and a LAST_STATE=4 instance,
// each with an expected-event queue checked by a monitor on every output change.
module tb_state_sequencer;

  localparam int W = 41;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  logic       a_reset = 1'b1, a_start = 1'b0, a_pause = 1'b0, a_skip = 1'b0, a_loop = 1'b0;
  logic [4:0] a_state;
  logic       a_slow, a_running, a_paused, a_done;
  logic       b_reset = 1'b1, b_start = 1'b0, b_pause = 1'b0, b_skip = 1'b0, b_loop = 1'b0;
  logic [4:0] b_state;
  logic       b_slow, b_running, b_paused, b_done;

  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  state_sequencer dut_a (
    .fourtyfiveHz_clock (clk),
    .reset              (a_reset),
    .start              (a_start),
    .pause              (a_pause),
    .skip               (a_skip),
    .loop_en            (a_loop),
    .state              (a_state),
    .slow_state         (a_slow),
    .running            (a_running),
    .paused             (a_paused),
    .done               (a_done)
  );

  state_sequencer #(.LAST_STATE(5'd4)) dut_b (
    .fourtyfiveHz_clock (clk),
    .reset              (b_reset),
    .start              (b_start),
    .pause              (b_pause),
    .skip               (b_skip),
    .loop_en            (b_loop),
    .state              (b_state),
    .slow_state         (b_slow),
    .running            (b_running),
    .paused             (b_paused),
    .done               (b_done)
  );

  function automatic logic [W-1:0] ev(input int c, input logic [4:0] s, input logic slow,
                                      input logic run, input logic pau, input logic dn);
    logic [31:0] c32;
    c32 = c;
    return {c32, s, slow, run, pau, dn};
  endfunction

  task automatic report_fail(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    $display("FAIL %s got cyc=%0d state=%0d slow=%0b run=%0b paused=%0b done=%0b | exp cyc=%0d state=%0d slow=%0b run=%0b paused=%0b done=%0b",
             name, got[40:9], got[8:4], got[3], got[2], got[1], got[0],
             exp[40:9], exp[8:4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  // driver tasks: inputs change 2 time units after a rising edge
  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_a(input int t, input logic st, input logic pa, input logic sk);
    at(t);
    a_start = st; a_pause = pa; a_skip = sk;
    at(t + 1);
    a_start = 1'b0; a_pause = 1'b0; a_skip = 1'b0;
  endtask

  task automatic pulse_b(input int t, input logic st, input logic pa, input logic sk);
    at(t);
    b_start = st; b_pause = pa; b_skip = sk;
    at(t + 1);
    b_start = 1'b0; b_pause = 1'b0; b_skip = 1'b0;
  endtask

  // scoreboard monitors: compare on every change of the observed outputs
  logic [8:0] last_a, last_b;
  logic       first_a = 1'b1, first_b = 1'b1;

  always @(negedge clk) begin
    logic [8:0]   snap;
    logic [W-1:0] obs, exp;
    logic [31:0]  c32;
    snap = {a_state, a_slow, a_running, a_paused, a_done};
    if (first_a || snap != last_a) begin
      c32 = cyc;
      obs = {c32, snap};
      tests++;
      if (exp_qa.size() == 0) begin
        fails++;
        report_fail("a_unexpected", obs, '0);
      end else begin
        exp = exp_qa.pop_front();
        if (obs !== exp) begin
          fails++;
          report_fail("a_event", obs, exp);
        end
      end
      first_a = 1'b0;
      last_a  = snap;
    end
  end

  always @(negedge clk) begin
    logic [8:0]   snap;
    logic [W-1:0] obs, exp;
    logic [31:0]  c32;
    snap = {b_state, b_slow, b_running, b_paused, b_done};
    if (first_b || snap != last_b) begin
      c32 = cyc;
      obs = {c32, snap};
      tests++;
      if (exp_qb.size() == 0) begin
        fails++;
        report_fail("b_unexpected", obs, '0);
      end else begin
        exp = exp_qb.pop_front();
        if (obs !== exp) begin
          fails++;
          report_fail("b_event", obs, exp);
        end
      end
      first_b = 1'b0;
      last_b  = snap;
    end
  end

  initial begin
    // instance a: default parameters
    exp_qa.push_back(ev(1,   5'd0, 0, 0, 0, 0));  // reset state
    exp_qa.push_back(ev(11,  5'd1, 0, 1, 0, 0));  // start at 10
    exp_qa.push_back(ev(56,  5'd2, 0, 1, 0, 0));  // 45 cycles in state 1
    exp_qa.push_back(ev(66,  5'd2, 0, 1, 1, 0));  // pause 10 cycles into state 2
    exp_qa.push_back(ev(165, 5'd2, 0, 1, 0, 0));  // resume after 100 frozen edges
    exp_qa.push_back(ev(201, 5'd3, 1, 1, 0, 0));  // state 2 lasted 145 cycles
    exp_qa.push_back(ev(336, 5'd4, 1, 1, 0, 0));  // slow: 135
    exp_qa.push_back(ev(471, 5'd5, 0, 1, 0, 0));  // slow: 135
    exp_qa.push_back(ev(516, 5'd6, 1, 1, 0, 0));  // fast: 45
    exp_qa.push_back(ev(651, 5'd7, 1, 1, 0, 0));  // slow: 135
    exp_qa.push_back(ev(661, 5'd7, 1, 1, 1, 0));  // pause+skip: pause wins
    exp_qa.push_back(ev(671, 5'd0, 0, 0, 0, 0));  // reset while paused

    // instance b: LAST_STATE=4, skip-driven
    exp_qb.push_back(ev(1,   5'd0, 0, 0, 0, 0));
    exp_qb.push_back(ev(11,  5'd1, 0, 1, 0, 0));
    exp_qb.push_back(ev(14,  5'd2, 0, 1, 0, 0));
    exp_qb.push_back(ev(17,  5'd3, 1, 1, 0, 0));
    exp_qb.push_back(ev(20,  5'd4, 1, 1, 0, 0));
    exp_qb.push_back(ev(23,  5'd0, 0, 0, 0, 1));  // loop_en=0: done, back to idle
    exp_qb.push_back(ev(24,  5'd0, 0, 0, 0, 0));
    exp_qb.push_back(ev(31,  5'd1, 0, 1, 0, 0));
    exp_qb.push_back(ev(34,  5'd2, 0, 1, 0, 0));
    exp_qb.push_back(ev(37,  5'd3, 1, 1, 0, 0));
    exp_qb.push_back(ev(40,  5'd4, 1, 1, 0, 0));
    exp_qb.push_back(ev(43,  5'd1, 0, 1, 0, 1));  // loop_en=1: wrap with done
    exp_qb.push_back(ev(44,  5'd1, 0, 1, 0, 0));
    exp_qb.push_back(ev(88,  5'd2, 0, 1, 0, 0));  // skip coincides with expiry
    exp_qb.push_back(ev(133, 5'd3, 1, 1, 0, 0));
    exp_qb.push_back(ev(268, 5'd4, 1, 1, 0, 0));
    exp_qb.push_back(ev(403, 5'd1, 0, 1, 0, 1));  // natural wrap
    exp_qb.push_back(ev(404, 5'd1, 0, 1, 0, 0));
    exp_qb.push_back(ev(411, 5'd0, 0, 0, 0, 0));  // reset

    at(3);
    a_reset = 1'b0;
    b_reset = 1'b0;

    fork
      begin
        pulse_a(5, 0, 1, 0);    // pause in idle: ignored
        pulse_a(6, 0, 0, 1);    // skip in idle: ignored
        pulse_a(10, 1, 0, 0);
        pulse_a(20, 1, 0, 0);   // start while running: ignored
        pulse_a(65, 0, 1, 0);
        pulse_a(164, 0, 1, 0);
        pulse_a(660, 0, 1, 1);
        pulse_a(665, 0, 0, 1);  // skip while paused: ignored
        pulse_a(667, 1, 0, 0);  // start while paused: ignored
        at(670);
        a_reset = 1'b1;
        at(671);
        a_reset = 1'b0;
      end
      begin
        pulse_b(10, 1, 0, 0);
        pulse_b(13, 0, 0, 1);
        pulse_b(16, 0, 0, 1);
        pulse_b(19, 0, 0, 1);
        pulse_b(22, 0, 0, 1);
        at(25);
        b_loop = 1'b1;
        pulse_b(30, 1, 0, 0);
        pulse_b(33, 0, 0, 1);
        pulse_b(36, 0, 0, 1);
        pulse_b(39, 0, 0, 1);
        pulse_b(42, 0, 0, 1);
        pulse_b(87, 0, 0, 1);
        at(410);
        b_reset = 1'b1;
        at(411);
        b_reset = 1'b0;
      end
    join

    at(700);
    while (exp_qa.size() != 0) begin
      logic [W-1:0] e;
      e = exp_qa.pop_front();
      tests++;
      fails++;
      report_fail("a_missing", '0, e);
    end
    while (exp_qb.size() != 0) begin
      logic [W-1:0] e;
      e = exp_qb.pop_front();
      tests++;
      fails++;
      report_fail("b_missing", '0, e);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    tests++;
    fails++;
    $display("FAIL timeout at cyc=%0d required finish before cyc=700", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
